// File: rtl/bcd_pkg.sv
// Shared BCD constants and validity helpers for the decade counter family.
package bcd_pkg;

  localparam int unsigned BCD_W          = 4;
  localparam logic [BCD_W-1:0] BCD_NINE  = 4'd9;
  localparam int unsigned BCD_MAX_DIGITS = 16;
  localparam int unsigned BCD_VEC_W      = BCD_W * BCD_MAX_DIGITS;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] nibble);
    return nibble <= BCD_NINE;
  endfunction

  // Callers zero-extend both operands; once every nibble is <= 9 the binary
  // compare orders values exactly as the decimal compare would.
  function automatic logic bcd_all_le(input logic [BCD_VEC_W-1:0] vec,
                                      input logic [BCD_VEC_W-1:0] lim);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (!bcd_valid(vec[i*BCD_W +: BCD_W])) ok = 1'b0;
    end
    return ok && (vec <= lim);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One registered BCD decade: load beats step; step counts up or down with 9<->0 wrap.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             step,
  input  logic             up,
  output logic [BCD_W-1:0] digit,
  output logic             at9,
  output logic             at0
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      digit <= '0;
    end else if (load) begin
      digit <= ld_val;
    end else if (step) begin
      if (up) digit <= at9 ? '0 : digit + BCD_W'(1);
      else    digit <= at0 ? BCD_NINE : digit - BCD_W'(1);
    end
  end

  always_comb begin
    at9 = (digit == BCD_NINE);
    at0 = (digit == '0);
  end

endmodule

// File: rtl/bcd_updown_counter_n.sv
// N-digit up/down BCD counter with programmable terminal value, checked parallel
// load and ENP/ENT cascade enables.
module bcd_updown_counter_n
  import bcd_pkg::*;
#(
  parameter int unsigned               DIGITS  = 2,
  parameter logic [BCD_W*DIGITS-1:0]   MAX_BCD = {DIGITS{4'h9}}
) (
  input  logic                      CLK,
  input  logic                      CLR,
  input  logic                      LOAD,
  input  logic [BCD_W*DIGITS-1:0]   DATA,
  input  logic                      ENP,
  input  logic                      ENT,
  input  logic                      UP,
  output logic [BCD_W*DIGITS-1:0]   Q,
  output logic                      RCO,
  output logic [DIGITS-1:0]         DIGIT_RCO,
  output logic                      LOAD_ERR
);

  localparam int unsigned QW = BCD_W * DIGITS;

  logic [DIGITS-1:0] at9, at0, flag, carry, step;
  logic [QW-1:0]     ld_vec;
  logic              count_en, term, wrap, data_ok, cell_load;

  assign data_ok = bcd_all_le(BCD_VEC_W'(DATA), BCD_VEC_W'(MAX_BCD));

  // The terminal wrap reuses the cells' load path: a counting edge at the
  // terminal state loads 0 (up) or MAX_BCD (down) instead of stepping.
  always_comb begin
    count_en  = ~LOAD & ENP & ENT;
    term      = UP ? (Q == MAX_BCD) : (Q == '0);
    wrap      = count_en & term;
    cell_load = (LOAD & data_ok) | wrap;
    ld_vec    = LOAD ? DATA : (UP ? '0 : MAX_BCD);
    RCO       = ENT & term;
    flag      = UP ? at9 : at0;
    DIGIT_RCO = {DIGITS{ENT}} & carry;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign carry[g] = &flag[g:0];

    if (g == 0) begin : g_first
      assign step[g] = count_en;
    end else begin : g_rest
      assign step[g] = count_en & carry[g-1];
    end

    bcd_digit_cell u_cell (
      .clk    (CLK),
      .clr    (CLR),
      .load   (cell_load),
      .ld_val (ld_vec[g*BCD_W +: BCD_W]),
      .step   (step[g]),
      .up     (UP),
      .digit  (Q[g*BCD_W +: BCD_W]),
      .at9    (at9[g]),
      .at0    (at0[g])
    );
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) LOAD_ERR <= 1'b0;
    else     LOAD_ERR <= LOAD & ~data_ok;
  end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Self-checking bench: directed scenarios plus a randomized run against a decimal model.
module tb_bcd_updown_counter_n;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: two digits, terminal 19
  logic       a_load = 1'b0, a_enp = 1'b0, a_ent = 1'b0, a_up = 1'b0;
  logic [7:0] a_data = '0;
  logic [7:0] a_q;
  logic       a_rco, a_err;
  logic [1:0] a_drco;

  bcd_updown_counter_n #(.DIGITS(2), .MAX_BCD(8'h19)) u_a (
    .CLK(clk), .CLR(clr), .LOAD(a_load), .DATA(a_data), .ENP(a_enp), .ENT(a_ent),
    .UP(a_up), .Q(a_q), .RCO(a_rco), .DIGIT_RCO(a_drco), .LOAD_ERR(a_err));

  // Cascade pair: lo.RCO feeds hi.ENT
  logic        c_load = 1'b0, c_enp = 1'b0, c_ent = 1'b0, c_up = 1'b0;
  logic [15:0] c_data = '0;
  logic [7:0]  lo_q, hi_q;
  logic        lo_rco, hi_rco, lo_err, hi_err;
  logic [1:0]  lo_drco, hi_drco;

  bcd_updown_counter_n #(.DIGITS(2), .MAX_BCD(8'h19)) u_lo (
    .CLK(clk), .CLR(clr), .LOAD(c_load), .DATA(c_data[7:0]), .ENP(c_enp), .ENT(c_ent),
    .UP(c_up), .Q(lo_q), .RCO(lo_rco), .DIGIT_RCO(lo_drco), .LOAD_ERR(lo_err));

  bcd_updown_counter_n #(.DIGITS(2), .MAX_BCD(8'h19)) u_hi (
    .CLK(clk), .CLR(clr), .LOAD(c_load), .DATA(c_data[15:8]), .ENP(c_enp), .ENT(lo_rco),
    .UP(c_up), .Q(hi_q), .RCO(hi_rco), .DIGIT_RCO(hi_drco), .LOAD_ERR(hi_err));

  // Instance D: three digits, terminal 999
  logic        d_load = 1'b0, d_enp = 1'b0, d_ent = 1'b0, d_up = 1'b0;
  logic [11:0] d_data = '0;
  logic [11:0] d_q;
  logic        d_rco, d_err;
  logic [2:0]  d_drco;

  bcd_updown_counter_n #(.DIGITS(3), .MAX_BCD(12'h999)) u_d (
    .CLK(clk), .CLR(clr), .LOAD(d_load), .DATA(d_data), .ENP(d_enp), .ENT(d_ent),
    .UP(d_up), .Q(d_q), .RCO(d_rco), .DIGIT_RCO(d_drco), .LOAD_ERR(d_err));

  function automatic logic [7:0] to_bcd2(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 clr = 1'b1;
    #2;
    total++; if (a_q !== 8'h00)   begin bad++; $display("FAIL reset_a_q: got %h want 00", a_q); end
    total++; if (a_err !== 1'b0)  begin bad++; $display("FAIL reset_a_err: got %b want 0", a_err); end
    total++; if (d_q !== 12'h000) begin bad++; $display("FAIL reset_d_q: got %h want 000", d_q); end
    total++; if ({hi_q, lo_q} !== 16'h0000) begin bad++; $display("FAIL reset_c_q: got %h want 0000", {hi_q, lo_q}); end
    a_load = 1'b1; a_data = 8'h05; a_enp = 1'b1; a_ent = 1'b1; a_up = 1'b1;
    tick();
    total++; if (a_q !== 8'h00) begin bad++; $display("FAIL reset_beats_load: got %h want 00", a_q); end
    clr = 1'b0; a_load = 1'b0; a_enp = 1'b0;
  endtask

  task automatic test_clr_midcount();
    a_load = 1'b1; a_data = 8'h07;
    tick();
    a_load = 1'b0;
    total++; if (a_q !== 8'h07) begin bad++; $display("FAIL clr_setup: got %h want 07", a_q); end
    a_enp = 1'b1; a_ent = 1'b1; a_up = 1'b1;
    #2 clr = 1'b1;
    #1;
    total++; if (a_q !== 8'h00)  begin bad++; $display("FAIL clr_async_q: got %h want 00", a_q); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL clr_async_err: got %b want 0", a_err); end
    tick();
    total++; if (a_q !== 8'h00) begin bad++; $display("FAIL clr_hold_q: got %h want 00", a_q); end
    clr = 1'b0; a_enp = 1'b0;
    a_load = 1'b1; a_data = 8'h3F;
    tick();
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL clr_err_setup: got %b want 1", a_err); end
    #2 clr = 1'b1;
    #1;
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL clr_clears_err: got %b want 0", a_err); end
    tick();
    clr = 1'b0; a_load = 1'b0;
  endtask

  task automatic test_count_up();
    int v;
    a_load = 1'b1; a_data = 8'h08; a_enp = 1'b1; a_ent = 1'b1; a_up = 1'b1;
    tick();
    a_load = 1'b0;
    total++; if (a_q !== 8'h08) begin bad++; $display("FAIL up_load: got %h want 08", a_q); end
    for (int k = 1; k <= 13; k++) begin
      tick();
      v = (8 + k) % 20;
      total++; if (a_q !== to_bcd2(v)) begin bad++; $display("FAIL up_q step %0d: got %h want %h", k, a_q, to_bcd2(v)); end
      total++; if (a_rco !== (v == 19)) begin bad++; $display("FAIL up_rco step %0d: got %b want %b", k, a_rco, (v == 19)); end
    end
  endtask

  task automatic test_count_down();
    int v;
    a_load = 1'b1; a_data = 8'h01; a_enp = 1'b1; a_ent = 1'b1; a_up = 1'b0;
    tick();
    a_load = 1'b0;
    total++; if (a_rco !== 1'b0) begin bad++; $display("FAIL dn_rco_at01: got %b want 0", a_rco); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      v = (21 - k) % 20;
      total++; if (a_q !== to_bcd2(v)) begin bad++; $display("FAIL dn_q step %0d: got %h want %h", k, a_q, to_bcd2(v)); end
      total++; if (a_rco !== (v == 0)) begin bad++; $display("FAIL dn_rco step %0d: got %b want %b", k, a_rco, (v == 0)); end
    end
    a_load = 1'b1; a_data = 8'h01; a_ent = 1'b0;
    tick();
    a_load = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++; if (a_q !== 8'h01)  begin bad++; $display("FAIL dn_ent0_q: got %h want 01", a_q); end
      total++; if (a_rco !== 1'b0) begin bad++; $display("FAIL dn_ent0_rco: got %b want 0", a_rco); end
    end
    a_load = 1'b1; a_data = 8'h00;
    tick();
    a_load = 1'b0;
    total++; if (a_rco !== 1'b0) begin bad++; $display("FAIL dn_ent0_rco_at00: got %b want 0", a_rco); end
    a_ent = 1'b1;
    #1;
    total++; if (a_rco !== 1'b1) begin bad++; $display("FAIL dn_rco_at00: got %b want 1", a_rco); end
    a_enp = 1'b0;
  endtask

  task automatic test_load();
    a_enp = 1'b1; a_ent = 1'b1; a_up = 1'b1;
    a_load = 1'b1; a_data = 8'h12;
    tick();
    total++; if (a_q !== 8'h12)  begin bad++; $display("FAIL load_12: got %h want 12", a_q); end
    a_data = 8'h1A;
    tick();
    total++; if (a_q !== 8'h12)  begin bad++; $display("FAIL load_1A_q: got %h want 12", a_q); end
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL load_1A_err: got %b want 1", a_err); end
    a_load = 1'b0; a_enp = 1'b0;
    tick();
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL load_err_pulse: got %b want 0", a_err); end
    a_load = 1'b1; a_data = 8'h25; a_enp = 1'b1;
    tick();
    total++; if (a_q !== 8'h12)  begin bad++; $display("FAIL load_25_q: got %h want 12", a_q); end
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL load_25_err: got %b want 1", a_err); end
    a_data = 8'h15;
    tick();
    total++; if (a_q !== 8'h15)  begin bad++; $display("FAIL load_15_q: got %h want 15", a_q); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL load_15_err: got %b want 0", a_err); end
    a_data = 8'h19;
    tick();
    total++; if (a_q !== 8'h19)  begin bad++; $display("FAIL load_max_q: got %h want 19", a_q); end
    a_data = 8'h20;
    tick();
    total++; if (a_q !== 8'h19)  begin bad++; $display("FAIL load_over_q: got %h want 19", a_q); end
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL load_over_err: got %b want 1", a_err); end
    a_load = 1'b0; a_enp = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    a_load = 1'b1; a_data = 8'h1A;
    tick();
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL b2b_first_err: got %b want 1", a_err); end
    a_data = 8'h9F;
    tick();
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL b2b_second_err: got %b want 1", a_err); end
    total++; if (a_q !== 8'h19)  begin bad++; $display("FAIL b2b_q_hold: got %h want 19", a_q); end
    a_data = 8'h03;
    tick();
    total++; if (a_q !== 8'h03)  begin bad++; $display("FAIL b2b_valid_q: got %h want 03", a_q); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL b2b_valid_err: got %b want 0", a_err); end
    a_load = 1'b0;
  endtask

  task automatic test_hold_enp();
    a_load = 1'b1; a_data = 8'h19;
    tick();
    a_load = 1'b0; a_enp = 1'b0; a_ent = 1'b1; a_up = 1'b1;
    tick();
    total++; if (a_q !== 8'h19)    begin bad++; $display("FAIL hold_q: got %h want 19", a_q); end
    total++; if (a_rco !== 1'b1)   begin bad++; $display("FAIL hold_rco: got %b want 1", a_rco); end
    total++; if (a_drco !== 2'b01) begin bad++; $display("FAIL hold_drco: got %b want 01", a_drco); end
    a_up = 1'b0;
    #1;
    total++; if (a_rco !== 1'b0) begin bad++; $display("FAIL hold_rco_down: got %b want 0", a_rco); end
  endtask

  task automatic test_cascade();
    int n;
    logic [15:0] exp;
    c_load = 1'b1; c_data = 16'h0000; c_enp = 1'b1; c_ent = 1'b1; c_up = 1'b1;
    tick();
    c_load = 1'b0;
    total++; if ({hi_q, lo_q} !== 16'h0000) begin bad++; $display("FAIL casc_start: got %h want 0000", {hi_q, lo_q}); end
    for (int k = 1; k <= 405; k++) begin
      tick();
      n = k % 400;
      exp = {to_bcd2(n / 20), to_bcd2(n % 20)};
      total++; if ({hi_q, lo_q} !== exp) begin bad++; $display("FAIL casc step %0d: got %h want %h", k, {hi_q, lo_q}, exp); end
    end
    c_enp = 1'b0;
  endtask

  task automatic test_three_digit();
    d_load = 1'b1; d_data = 12'h099; d_up = 1'b1; d_ent = 1'b1; d_enp = 1'b0;
    tick();
    d_load = 1'b0;
    total++; if (d_drco !== 3'b011) begin bad++; $display("FAIL d3_drco_099: got %b want 011", d_drco); end
    total++; if (d_rco !== 1'b0)    begin bad++; $display("FAIL d3_rco_099: got %b want 0", d_rco); end
    d_enp = 1'b1;
    tick();
    total++; if (d_q !== 12'h100) begin bad++; $display("FAIL d3_carry: got %h want 100", d_q); end
    d_load = 1'b1; d_data = 12'h999;
    tick();
    d_load = 1'b0; d_enp = 1'b0;
    total++; if (d_rco !== 1'b1)    begin bad++; $display("FAIL d3_rco_999: got %b want 1", d_rco); end
    total++; if (d_drco !== 3'b111) begin bad++; $display("FAIL d3_drco_999: got %b want 111", d_drco); end
    d_enp = 1'b1;
    tick();
    total++; if (d_q !== 12'h000) begin bad++; $display("FAIL d3_wrap_up: got %h want 000", d_q); end
    d_up = 1'b0; d_enp = 1'b0;
    #1;
    total++; if (d_drco !== 3'b111) begin bad++; $display("FAIL d3_drco_dn000: got %b want 111", d_drco); end
    d_enp = 1'b1;
    tick();
    total++; if (d_q !== 12'h999) begin bad++; $display("FAIL d3_wrap_dn: got %h want 999", d_q); end
    d_enp = 1'b0;
  endtask

  task automatic test_random();
    int  m_q, dv, hn, ln;
    bit  m_err, dvalid;
    logic [1:0] exp_drco;
    logic exp_rco;
    a_load = 1'b1; a_data = 8'h00;
    tick();
    a_load = 1'b0;
    m_q = 0; m_err = 1'b0;
    for (int k = 0; k < 300; k++) begin
      a_load = ($urandom_range(0, 3) == 0);
      a_data = 8'($urandom);
      a_enp  = 1'($urandom);
      a_ent  = 1'($urandom);
      a_up   = 1'($urandom);
      #1;
      exp_rco     = a_ent & (a_up ? (m_q == 19) : (m_q == 0));
      exp_drco[0] = a_ent & (a_up ? (m_q % 10 == 9)  : (m_q % 10 == 0));
      exp_drco[1] = a_ent & (a_up ? (m_q % 100 == 99) : (m_q % 100 == 0));
      total++; if (a_rco !== exp_rco)   begin bad++; $display("FAIL rnd_rco %0d: got %b want %b", k, a_rco, exp_rco); end
      total++; if (a_drco !== exp_drco) begin bad++; $display("FAIL rnd_drco %0d: got %b want %b", k, a_drco, exp_drco); end
      tick();
      hn = int'(a_data[7:4]);
      ln = int'(a_data[3:0]);
      dv = hn * 10 + ln;
      dvalid = (hn <= 9) && (ln <= 9) && (dv <= 19);
      if (a_load) begin
        if (dvalid) begin m_q = dv; m_err = 1'b0; end
        else m_err = 1'b1;
      end else begin
        m_err = 1'b0;
        if (a_enp && a_ent) m_q = a_up ? ((m_q == 19) ? 0 : m_q + 1) : ((m_q == 0) ? 19 : m_q - 1);
      end
      total++; if (a_q !== to_bcd2(m_q)) begin bad++; $display("FAIL rnd_q %0d: got %h want %h", k, a_q, to_bcd2(m_q)); end
      total++; if (a_err !== m_err)      begin bad++; $display("FAIL rnd_err %0d: got %b want %b", k, a_err, m_err); end
    end
    a_load = 1'b0; a_enp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clr_midcount();
    test_count_up();
    test_count_down();
    test_load();
    test_back_to_back();
    test_hold_enp();
    test_cascade();
    test_three_digit();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
